// File: rtl/rgmii_idelay_sched.sv
// rgmii_idelay_sched: IDELAYCTRL reset/RDY sequencing and per-lane IDELAYE2 tap loading
module rgmii_idelay_sched #(
    parameter int          N_LANES     = 5,
    parameter int          RST_CYCLES  = 16,
    parameter int          RDY_TIMEOUT = 4096,
    parameter logic [4:0]  DEFAULT_TAP = 5'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               host_we,
    input  logic [2:0]         host_lane,
    input  logic [4:0]         host_tap,
    output logic [4:0]         rd_tap,
    input  logic               ctrl_rdy,
    output logic               idelayctrl_rst,
    output logic [4:0]         idelay_value,
    output logic [N_LANES-1:0] idelay_ld,
    output logic               busy,
    output logic               ready,
    output logic               timeout
);
    localparam int RW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
    localparam int TW = RDY_TIMEOUT > 1 ? $clog2(RDY_TIMEOUT) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(RDY_TIMEOUT - 1);
    localparam logic [3:0]    NL       = 4'(N_LANES);

    typedef enum logic [2:0] {CTRL_RST, WAIT_RDY, LOAD_SET, LOAD_PULSE, IDLE, FAIL} state_t;

    state_t                  state_q, state_d;
    logic [RW-1:0]           rcnt_q, rcnt_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [N_LANES-1:0][4:0] tap_q, tap_d;
    logic [N_LANES-1:0]      dirty_q, dirty_d;
    logic [2:0]              cur_q, cur_d, low;
    logic                    sync1_q, sync2_q;
    logic                    rst_out_q, rst_out_d;
    logic [4:0]              val_q, val_d;
    logic [N_LANES-1:0]      ld_q, ld_d;
    logic                    busy_q, busy_d, ready_q, ready_d, timeout_q, timeout_d;
    logic                    lane_ok, wr_ok;

    assign lane_ok        = {1'b0, host_lane} < NL;
    assign wr_ok          = host_we && lane_ok;
    assign rd_tap         = lane_ok ? tap_q[host_lane] : 5'd0;
    assign idelayctrl_rst = rst_out_q;
    assign idelay_value   = val_q;
    assign idelay_ld      = ld_q;
    assign busy           = busy_q;
    assign ready          = ready_q;
    assign timeout        = timeout_q;

    // Lowest-index dirty lane is serviced first
    always_comb begin
        low = '0;
        for (int i = N_LANES - 1; i >= 0; i--) if (dirty_q[i]) low = 3'(i);
    end

    // Next state, table/dirty updates and registered output values
    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        tcnt_d    = tcnt_q;
        tap_d     = tap_q;
        dirty_d   = dirty_q;
        cur_d     = cur_q;
        timeout_d = timeout_q;
        val_d     = val_q;
        case (state_q)
            CTRL_RST: begin
                if (rcnt_q == RST_LAST) begin
                    state_d = WAIT_RDY;
                    tcnt_d  = '0;
                end else rcnt_d = rcnt_q + 1'b1;
            end
            WAIT_RDY: begin
                if (sync2_q) state_d = IDLE;
                else if (tcnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = FAIL;
                end else tcnt_d = tcnt_q + 1'b1;
            end
            IDLE: begin
                if (!sync2_q) begin
                    dirty_d = '1;
                    tcnt_d  = '0;
                    state_d = WAIT_RDY;
                end else if (|dirty_q) begin
                    cur_d   = low;
                    state_d = LOAD_SET;
                end
            end
            LOAD_SET: state_d = LOAD_PULSE;
            LOAD_PULSE: begin
                dirty_d[cur_q] = 1'b0;
                state_d        = IDLE;
            end
            default: state_d = FAIL;
        endcase
        // A host write after the FSM update so that a same-cycle set beats the dirty clear
        if (wr_ok) begin
            tap_d[host_lane]   = host_tap;
            dirty_d[host_lane] = 1'b1;
        end
        if (start) begin
            state_d   = CTRL_RST;
            rcnt_d    = '0;
            dirty_d   = '1;
            timeout_d = 1'b0;
        end
        // Tap value is captured once on LOAD_SET entry and held through the pulse
        if (state_q == IDLE && state_d == LOAD_SET) val_d = tap_d[cur_d];
        rst_out_d = state_d == CTRL_RST;
        ld_d      = state_d == LOAD_PULSE ? N_LANES'(1) << cur_d : '0;
        busy_d    = state_d != IDLE;
        ready_d   = state_d == IDLE && sync1_q && dirty_d == '0;
    end

    // Two-flop synchronizer for the asynchronous IDELAYCTRL RDY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ctrl_rdy;
            sync2_q <= sync1_q;
        end
    end

    // State, table and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CTRL_RST;
            rcnt_q    <= '0;
            tcnt_q    <= '0;
            tap_q     <= {N_LANES{DEFAULT_TAP}};
            dirty_q   <= '1;
            cur_q     <= '0;
            rst_out_q <= 1'b1;
            val_q     <= '0;
            ld_q      <= '0;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            tcnt_q    <= tcnt_d;
            tap_q     <= tap_d;
            dirty_q   <= dirty_d;
            cur_q     <= cur_d;
            rst_out_q <= rst_out_d;
            val_q     <= val_d;
            ld_q      <= ld_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            timeout_q <= timeout_d;
        end
    end
endmodule
